// File: rtl/adc_sample_drain.sv
// adc_sample_drain: on a sample-store IRQ, reads NUM_SLOTS words over an
// Avalon-MM master, streams the low 12 bits of each word out with its slot
// index, then clears the IRQ with a W1C write. An 8-entry FIFO plus a
// credit check (buffered + in-flight < 8) lets the stream stall the reads
// without ever losing a sample.
module adc_sample_drain #(
    parameter int unsigned NUM_SLOTS    = 64,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clock_clk,
    input  logic        reset_sink_reset_n,
    input  logic        enable,
    input  logic        store_irq,
    output logic [6:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        src_valid,
    input  logic        src_ready,
    output logic [11:0] src_data,
    output logic [5:0]  src_slot,
    output logic        src_last,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned SLOT_W     = 6;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned PTR_W      = 3;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned INFL_W     = 3;
    localparam int unsigned OCC_W      = 5;

    localparam logic [ADDR_W-1:0] IRQ_EN_ADDR = 7'd64;
    localparam logic [ADDR_W-1:0] IRQ_ST_ADDR = 7'd65;
    localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(NUM_SLOTS - 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [DATA_W-1:0] data;
    } sample_t;

    // Control state
    logic [2:0]        r_state;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic              r_hold_cnt;
    logic [ADDR_W-1:0] r_avm_address;
    logic              r_avm_read;
    logic              r_avm_write;
    logic [31:0]       r_avm_writedata;
    logic              r_busy;
    logic [15:0]       r_frame_count;

    // Read-return tracking: one valid/slot stage per cycle of read latency
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [SLOT_W-1:0]       r_pipe_slot [READ_LATENCY];

    // Sample FIFO
    sample_t           r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_fifo_count;
    logic              r_src_valid;

    // Next-state / combinational signals
    logic [2:0]        w_state_nxt;
    logic [SLOT_W-1:0] w_slot_nxt;
    logic              w_hold_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_rd_nxt;
    logic              w_wr_nxt;
    logic [31:0]       w_wdata_nxt;
    logic              w_fc_inc;
    logic [INFL_W-1:0] w_inflight;
    logic              w_credit;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_fifo_count_nxt;
    sample_t           w_push_data;
    sample_t           w_head;
    logic              w_unused;

    assign w_unused = ^{avm_readdata[31:DATA_W], 1'b0};

    // Reads issued but not yet in the FIFO: the strobe cycle plus the latency pipe
    always_comb begin
        w_inflight = INFL_W'(r_avm_read);
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            w_inflight = w_inflight + INFL_W'(r_pipe_vld[i]);
        end
    end

    assign w_credit = (OCC_W'(r_fifo_count) + OCC_W'(w_inflight)) < OCC_W'(FIFO_DEPTH);

    // Frame sequencing and next bus cycle
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_addr_nxt  = '0;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_wdata_nxt = '0;
        w_fc_inc    = 1'b0;
        case (r_state)
            S_INIT: begin
                w_wr_nxt    = 1'b1;
                w_addr_nxt  = IRQ_EN_ADDR;
                w_wdata_nxt = 32'h1;
                w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (enable && store_irq) begin
                    w_state_nxt = S_READ;
                    w_slot_nxt  = '0;
                end
            end
            S_READ: begin
                if (w_credit) begin
                    w_rd_nxt   = 1'b1;
                    w_addr_nxt = ADDR_W'(r_slot_cnt);
                    if (r_slot_cnt == LAST_SLOT) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_slot_nxt = r_slot_cnt + SLOT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (w_inflight == '0) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_wr_nxt    = 1'b1;
                w_addr_nxt  = IRQ_ST_ADDR;
                w_wdata_nxt = 32'h1;
                w_fc_inc    = 1'b1;
                w_hold_nxt  = 1'b0;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_hold_cnt) begin
                    w_hold_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // State, bus and status registers
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            r_state         <= S_INIT;
            r_slot_cnt      <= '0;
            r_hold_cnt      <= 1'b0;
            r_avm_address   <= '0;
            r_avm_read      <= 1'b0;
            r_avm_write     <= 1'b0;
            r_avm_writedata <= '0;
            r_busy          <= 1'b1;
            r_frame_count   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_slot_cnt      <= w_slot_nxt;
            r_hold_cnt      <= w_hold_nxt;
            r_avm_address   <= w_addr_nxt;
            r_avm_read      <= w_rd_nxt;
            r_avm_write     <= w_wr_nxt;
            r_avm_writedata <= w_wdata_nxt;
            r_busy          <= (w_state_nxt != S_IDLE);
            if (w_fc_inc) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Latency pipe: last stage lines up with valid avm_readdata
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                r_pipe_slot[i] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= r_avm_read;
            r_pipe_slot[0] <= r_avm_address[SLOT_W-1:0];
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_slot[i] <= r_pipe_slot[i-1];
            end
        end
    end

    assign w_push           = r_pipe_vld[READ_LATENCY-1];
    assign w_pop            = r_src_valid && src_ready;
    assign w_push_data.slot = r_pipe_slot[READ_LATENCY-1];
    assign w_push_data.data = avm_readdata[DATA_W-1:0];
    assign w_fifo_count_nxt = r_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // FIFO pointers and occupancy
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            r_src_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_fifo_count <= w_fifo_count_nxt;
            r_src_valid  <= (w_fifo_count_nxt != '0);
        end
    end

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge clock_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign w_head        = r_fifo_mem[r_rd_ptr];
    assign src_valid     = r_src_valid;
    assign src_data      = w_head.data;
    assign src_slot      = w_head.slot;
    assign src_last      = (w_head.slot == LAST_SLOT);
    assign avm_address   = r_avm_address;
    assign avm_read      = r_avm_read;
    assign avm_write     = r_avm_write;
    assign avm_writedata = r_avm_writedata;
    assign busy          = r_busy;
    assign frame_count   = r_frame_count;

endmodule
